cipher_char_uart_tx: RTL and testbench
======================================

Name: cipher_char_uart_tx

Overview:
Downstream consumer of the cipher core's 8-bit encoded_char output. It captures each valid encoded character into a small FIFO and serialises it off-chip as 8N1 UART frames on a single pin. This lets a host log the cipher's response stream through the limited TinyTapeout output pins. It also reports buffer occupancy and a sticky overflow flag.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit; integer >= 2
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
encoded_char  input  8  character from the cipher core
char_valid  input  1  one-cycle strobe; encoded_char is valid this cycle
clr_ovf  input  1  synchronous clear of the overflow flag
uart_tx  output  1  serial line; idle high
busy  output  1  high when the FIFO is non-empty or the TX FSM is not IDLE
overflow  output  1  sticky; a character was dropped
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset values, applied when rst is sampled high at a clock edge:
  - uart_tx=1, busy=0, overflow=0, fifo_level=0.
  - Pointers are zeroed and the FSM goes to IDLE.
  - Reset mid-frame aborts the frame, and uart_tx returns high on the next cycle.
- FIFO:
  - Push when char_valid=1 and full=0, where "full" is the registered flag at the start of the cycle.
  - If full=1, the character is dropped and overflow is set next cycle. This holds even if a pop occurs in the same cycle; there is no write-through on full.
  - Pop is requested only by the TX FSM in IDLE while empty=0.
  - Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both operations take effect.
  - Push into an empty FIFO does not bypass; the data becomes visible the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_level is registered and updates on the edge after push or pop.
- overflow:
  - Set on a dropped push.
  - Cleared by clr_ovf.
  - If set and clear happen in the same cycle, set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If empty=0, pop, latch the head byte into shreg, baud_cnt=0, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=shreg[bit_idx], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - uart_tx is driven from a register, so it is glitch-free.
- Frame timing:
  - One frame is 10*CLKS_PER_BIT cycles, followed by at least 1 IDLE cycle. Back-to-back frames are therefore 10*CLKS_PER_BIT+1 cycles apart.
- Latency:
  - char_valid is sampled at edge E0 into an empty FIFO with the FSM in IDLE.
  - The FSM pops at E1.
  - uart_tx is first low after E2, i.e. 2 cycles after the strobe edge.
- Width rules:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - bit_idx is 3 bits.
  - Pointers are $clog2(FIFO_DEPTH) bits. Full/empty are derived from a registered count, not from pointer equality.

Decomposition:
- Package cipher_uart_pkg:
  - typedef tx_state_t with the enum IDLE/START/DATA/STOP.
  - Constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- Sub-module char_fifo(DEPTH, WIDTH=8):
  - Owns the storage, pointers, level, full/empty and the drop flag.
  - The top level holds the TX FSM and the overflow register.

Test Plan:
1. Reset then a single char 0xA5 (CLKS_PER_BIT=4):
   - uart_tx goes low 2 cycles after the strobe.
   - Bits observed are 1,0,1,0,0,1,0,1 (LSB first), each 4 cycles, then stop high for 4 cycles.
   - busy falls after STOP; fifo_level reads 1 then 0.
2. Burst of 5 strobes on consecutive cycles, 0x01..0x05, FIFO_DEPTH=4:
   - The first pop frees a slot, so all 5 chars are accepted and level peaks at 4.
   - Frames arrive 41 cycles apart in order 0x01..0x05; overflow stays 0.
3. Burst of 7 strobes on consecutive cycles, 0x10..0x16:
   - The FIFO becomes full, so 0x15 and 0x16 are dropped and overflow=1.
   - The transmitted bytes are exactly 0x10..0x14, and overflow stays set afterwards.
4. clr_ovf handling:
   - clr_ovf=1 while overflow=1 and no drop: overflow reads 0 next cycle.
   - clr_ovf coincident with a dropped push: overflow stays 1.
5. rst asserted during DATA bit 3 of 0xFF with 2 chars queued:
   - On the next cycle uart_tx=1, fifo_level=0, busy=0.
   - No further frames are sent, and a new 0x3C then transmits correctly.
6. Pointer wrap:
   - Send 12 chars spaced 50 cycles apart, which wraps the FIFO 3 times.
   - All 12 are received intact; fifo_level never exceeds 1; the line is idle high between frames.

Source files
------------

// File: rtl/cipher_uart_pkg.sv
// Shared types and constants for the cipher character UART transmitter.
package cipher_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO; full/empty come from a registered occupancy count.
module char_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A push while full is lost even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign drop    = push && full;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PW'(1);
    end
    if (do_pop) rptr_d = rptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/cipher_char_uart_tx.sv
// Buffers encoded cipher characters and serialises them as 8N1 UART frames.
module cipher_char_uart_tx
  import cipher_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  encoded_char,
  input  logic                        char_valid,
  input  logic                        clr_ovf,
  output logic                        uart_tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  head;
  logic        empty, full, drop, pop;

  assign pop = (state_q == IDLE) && !empty;

  char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_valid),
    .wdata (encoded_char),
    .pop   (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  // Line level is a function of the current state, registered one cycle late.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = UART_IDLE_LEVEL;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shreg_d = head;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else baud_d = baud_q + BW'(1);
      end
      DATA: begin
        tx_d = shreg_q[bit_q];
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + BW'(1);
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else baud_d = baud_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase
    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx  = tx_q;
  assign overflow = ovf_q;
  assign busy     = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_cipher_char_uart_tx.sv
// Self-checking bench: cycle-level reference model plus a line decoder on uart_tx.
module tb_cipher_char_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst = 1'b1, char_valid = 1'b0, clr_ovf = 1'b0;
  logic [7:0]    encoded_char = 8'h00;
  logic          uart_tx, busy, overflow;
  logic [LW-1:0] fifo_level;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  cipher_char_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .encoded_char(encoded_char), .char_valid(char_valid),
    .clr_ovf(clr_ovf), .uart_tx(uart_tx), .busy(busy), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  // Reference model: a queue of accepted bytes and the edge at which the
  // transmitter last took one; a frame occupies 10*CPB cycles after that.
  int         ec = 0, m_free = 0, m_pop = -1000;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0, m_full;
  logic [7:0] mq[$], m_sent[$];

  always @(posedge clk) begin
    ec++;
    if (rst) begin
      mq.delete();
      m_free = ec + 1;
      m_pop  = -1000;
      m_ovf  = 1'b0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (ec >= m_free && mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_sent.push_back(m_byte);
        m_pop  = ec;
        m_free = ec + 10 * CPB + 1;
      end
      if (char_valid && !m_full) mq.push_back(encoded_char);
      if (char_valid && m_full) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    int d, slot;
    d = ec - m_pop - 1;
    if (d < 0 || d >= 10 * CPB) return 1'b1;
    slot = d / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  function automatic logic exp_busy();
    return (mq.size() > 0) || (ec < m_pop + 10 * CPB);
  endfunction

  function automatic logic [LW-1:0] exp_level();
    return LW'(mq.size());
  endfunction

  // Line decoder: samples mid-bit after seeing a start bit.
  logic [7:0] rx_q[$], rx_b;
  int         rx_t[$], rx_s;
  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        rx_s = ec;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(rx_b);
        rx_t.push_back(rx_s);
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete(); rx_t.delete(); m_sent.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({uart_tx, busy, overflow, fifo_level} !== {1'b1, 1'b0, 1'b0, LW'(0)}) begin
      mismatched++;
      $display("FAIL reset: tx/busy/ovf/lvl got %b/%b/%b/%0d want 1/0/0/0", uart_tx, busy, overflow, fifo_level);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_char();
    int t0;
    clear_rx();
    @(negedge clk); encoded_char = 8'hA5; char_valid = 1'b1;
    @(negedge clk); char_valid = 1'b0; t0 = ec;
    compared++;
    if (fifo_level !== LW'(1)) begin mismatched++; $display("FAIL single_level1: got %0d want 1", fifo_level); end
    @(negedge clk);
    compared++;
    if (fifo_level !== LW'(0)) begin mismatched++; $display("FAIL single_level0: got %0d want 0", fifo_level); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      compared++;
      if ({uart_tx, busy, overflow, fifo_level} !== {exp_tx(), exp_busy(), m_ovf, exp_level()}) begin
        mismatched++;
        $display("FAIL single_cycle %0d: tx/busy/ovf/lvl got %b/%b/%b/%0d want %b/%b/%b/%0d", ec,
                 uart_tx, busy, overflow, fifo_level, exp_tx(), exp_busy(), m_ovf, exp_level());
      end
    end
    compared++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      mismatched++; $display("FAIL single_byte: got %0d frames first %h want 1 frame a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    compared++;
    if (rx_t.size() != 1 || rx_t[0] - t0 != 2) begin
      mismatched++; $display("FAIL single_latency: got %0d want 2", rx_t.size() ? rx_t[0] - t0 : -1);
    end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_burst(input int n, input logic [7:0] base, input logic want_ovf);
    int peak, nexp;
    clear_rx();
    peak = 0;
    nexp = (n <= DEPTH + 1) ? n : DEPTH + 1;
    for (int c = 0; c < n + 45 * n; c++) begin
      @(negedge clk);
      compared++;
      if ({uart_tx, busy, overflow, fifo_level} !== {exp_tx(), exp_busy(), m_ovf, exp_level()}) begin
        mismatched++;
        $display("FAIL burst_cycle %0d: tx/busy/ovf/lvl got %b/%b/%b/%0d want %b/%b/%b/%0d", ec,
                 uart_tx, busy, overflow, fifo_level, exp_tx(), exp_busy(), m_ovf, exp_level());
      end
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      char_valid   = (c < n);
      encoded_char = base + 8'(c);
    end
    compared++;
    if (rx_q.size() != nexp) begin mismatched++; $display("FAIL burst_count: got %0d want %0d", rx_q.size(), nexp); end
    for (int i = 0; i < nexp && i < rx_q.size(); i++) begin
      compared++;
      if (rx_q[i] !== base + 8'(i)) begin mismatched++; $display("FAIL burst_byte %0d: got %h want %h", i, rx_q[i], base + 8'(i)); end
      if (i > 0) begin
        compared++;
        if (rx_t[i] - rx_t[i-1] != 10 * CPB + 1) begin
          mismatched++; $display("FAIL burst_spacing %0d: got %0d want %0d", i, rx_t[i] - rx_t[i-1], 10 * CPB + 1);
        end
      end
    end
    compared++;
    if (peak != DEPTH) begin mismatched++; $display("FAIL burst_peak: got %0d want %0d", peak, DEPTH); end
    compared++;
    if (overflow !== want_ovf) begin mismatched++; $display("FAIL burst_ovf: got %b want %b", overflow, want_ovf); end
  endtask

  task automatic test_clr_ovf();
    clear_rx();
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL clr_ovf_plain: got %b want 0", overflow); end
    for (int c = 0; c < 6 + 260; c++) begin
      @(negedge clk);
      if (c == 7) begin
        compared++;
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL clr_ovf_vs_drop: got %b want 1", overflow); end
      end
      compared++;
      if ({uart_tx, busy, overflow, fifo_level} !== {exp_tx(), exp_busy(), m_ovf, exp_level()}) begin
        mismatched++;
        $display("FAIL clr_cycle %0d: tx/busy/ovf/lvl got %b/%b/%b/%0d want %b/%b/%b/%0d", ec,
                 uart_tx, busy, overflow, fifo_level, exp_tx(), exp_busy(), m_ovf, exp_level());
      end
      char_valid   = (c < 6);
      encoded_char = 8'($urandom);
      clr_ovf      = (c == 5);
    end
    compared++;
    if (rx_q != m_sent) begin mismatched++; $display("FAIL clr_stream: got %0d frames want %0d", rx_q.size(), m_sent.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t0, lows;
    logic [7:0] seq [3];
    seq[0] = 8'hFF; seq[1] = 8'h11; seq[2] = 8'h22;
    clear_rx();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); char_valid = 1'b1; encoded_char = seq[i];
      if (i == 1) t0 = ec;
    end
    @(negedge clk); char_valid = 1'b0;
    while (ec < t0 + 1 + 18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    compared++;
    if ({uart_tx, busy, fifo_level} !== {1'b1, 1'b0, LW'(0)}) begin
      mismatched++; $display("FAIL midreset: tx/busy/lvl got %b/%b/%0d want 1/0/0", uart_tx, busy, fifo_level);
    end
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    compared++;
    if (lows != 0) begin mismatched++; $display("FAIL midreset_quiet: got %0d low cycles want 0", lows); end
    clear_rx();
    @(negedge clk); char_valid = 1'b1; encoded_char = 8'h3C;
    @(negedge clk); char_valid = 1'b0;
    repeat (50) @(negedge clk);
    compared++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      mismatched++; $display("FAIL midreset_next: got %0d frames first %h want 1 frame 3c", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] sent[$];
    int peak;
    clear_rx();
    peak = 0;
    for (int i = 0; i < 13; i++) begin
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        compared++;
        if ({uart_tx, busy, overflow, fifo_level} !== {exp_tx(), exp_busy(), m_ovf, exp_level()}) begin
          mismatched++;
          $display("FAIL wrap_cycle %0d: tx/busy/ovf/lvl got %b/%b/%b/%0d want %b/%b/%b/%0d", ec,
                   uart_tx, busy, overflow, fifo_level, exp_tx(), exp_busy(), m_ovf, exp_level());
        end
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        char_valid = (c == 0 && i < 12);
        encoded_char = 8'($urandom);
        if (char_valid) sent.push_back(encoded_char);
      end
    end
    compared++;
    if (peak > 1) begin mismatched++; $display("FAIL wrap_peak: got %0d want <=1", peak); end
    compared++;
    if (rx_q != sent) begin mismatched++; $display("FAIL wrap_stream: got %0d frames want %0d", rx_q.size(), sent.size()); end
  endtask

  task automatic test_random();
    clear_rx();
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      compared++;
      if ({uart_tx, busy, overflow, fifo_level} !== {exp_tx(), exp_busy(), m_ovf, exp_level()}) begin
        mismatched++;
        $display("FAIL random_cycle %0d: tx/busy/ovf/lvl got %b/%b/%b/%0d want %b/%b/%b/%0d", ec,
                 uart_tx, busy, overflow, fifo_level, exp_tx(), exp_busy(), m_ovf, exp_level());
      end
      char_valid   = (c < 800) && ($urandom_range(0, 11) == 0);
      clr_ovf      = ($urandom_range(0, 29) == 0);
      encoded_char = 8'($urandom);
    end
    compared++;
    if (rx_q != m_sent) begin mismatched++; $display("FAIL random_stream: got %0d frames want %0d", rx_q.size(), m_sent.size()); end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_burst(5, 8'h01, 1'b0);
    test_burst(7, 8'h10, 1'b1);
    test_clr_ovf();
    test_reset_mid_frame();
    test_pointer_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
